d_reg_pipe: RTL
===============

# d_reg_pipe

Parametrised multi-stage D register pipeline. It generalises the team's single D storage element, which has a true output and an inverted output, into a WIDTH-bit, DEPTH-stage delay line. Each stage carries a valid bit. The block adds enable and stall, mode-selected operation (shift, hold, broadcast load, flush) and an occupancy count. It sits between producer logic and any consumer needing a fixed, known delay with qualified data.

## Interface
- WIDTH, 8, data width per stage; must be ≥ 1
- DEPTH, 4, number of pipeline stages; must be ≥ 1; DEPTH = 1 is a single register
- RESET_VAL, '0, WIDTH-bit value loaded into every stage data register on reset and on flush
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk
- en  input  1  global enable; 0 forces hold regardless of mode
- mode  input  2  operation select: 2'b00 HOLD, 2'b01 SHIFT, 2'b10 LOAD_ALL, 2'b11 FLUSH
- d  input  WIDTH  data into stage 0 (SHIFT) or into all stages (LOAD_ALL)
- in_valid  input  1  qualifies d
- q  output  WIDTH  data of stage DEPTH-1
- q_n  output  WIDTH  bitwise inverse of q
- out_valid  output  1  valid bit of stage DEPTH-1
- fill_cnt  output  $clog2(DEPTH+1)  number of stages whose valid bit is set

## Operation
- State:
  - stage[0..DEPTH-1], WIDTH bits each
  - vld[0..DEPTH-1], 1 bit each
- Priority, highest first: reset, then en = 0, then mode.
- reset = 1:
  - every stage is set to RESET_VAL
  - every vld bit is cleared
  - after reset: q = RESET_VAL, q_n = ~RESET_VAL, out_valid = 0, fill_cnt = 0
- en = 0: all state holds. Any mode value is ignored.
- HOLD: all state holds. This mode is identical to en = 0.
- SHIFT:
  - stage[0] ← d and vld[0] ← in_valid
  - for i ≥ 1: stage[i] ← stage[i-1] and vld[i] ← vld[i-1]
  - data is captured whether in_valid is 0 or 1; in_valid = 0 inserts a bubble
- LOAD_ALL:
  - every stage ← d
  - every vld bit ← in_valid
  - the pipeline fills, or empties, in one cycle
- FLUSH:
  - every stage ← RESET_VAL
  - every vld bit ← 0
  - d and in_valid are ignored
- Outputs:
  - q = stage[DEPTH-1]
  - q_n = ~stage[DEPTH-1], computed combinationally from the register
  - out_valid = vld[DEPTH-1]
  - fill_cnt = combinational popcount of vld[]
- Width rules: fill_cnt is zero-extended. At DEPTH = 1 it is 1 bit wide; at DEPTH = 4 it is 3 bits wide.
- No overflow or full condition exists. In SHIFT, data leaving stage DEPTH-1 is discarded regardless of any downstream state.

## Timing
- Latency in SHIFT with en held at 1: a value presented on d at edge N appears on q, qualified by out_valid, after edge N+DEPTH-1. It is therefore visible during cycle N+DEPTH-1, i.e. DEPTH edges from capture to output inclusive of the capture edge.
- Throughput: one word per cycle while en = 1 and mode = SHIFT.
- Stall: any cycle with en = 0 or mode = HOLD stretches the latency by one cycle. No data or valid bit is lost.
- LOAD_ALL latency: q = d and out_valid = in_valid from the next edge.
- FLUSH:
  - out_valid = 0 and fill_cnt = 0 from the next edge
  - a SHIFT on the following cycle restarts filling from an empty pipeline
- Reset mid-operation: reset = 1 on any edge overrides en, mode and d. State equals the post-reset values from that edge on.
- Outputs are glitch-free register values. fill_cnt and q_n settle combinationally in the same cycle as the registers they derive from.
- Boundary at DEPTH = 1: SHIFT and LOAD_ALL behave identically, and fill_cnt ∈ {0,1}.

## Test plan
All scenarios use WIDTH = 8, DEPTH = 4, RESET_VAL = 8'h00.
- Reset: hold reset = 1 for 2 cycles with en = 1, mode = SHIFT, d = 8'hFF, in_valid = 1.
  - Required: q = 8'h00, q_n = 8'hFF, out_valid = 0, fill_cnt = 0 throughout.
- Latency: SHIFT in d = 8'hA5 with in_valid = 1 on one edge, then in_valid = 0.
  - Required: out_valid = 1 with q = 8'hA5 and q_n = 8'h5A exactly 4 edges after capture, for 1 cycle.
  - Required: fill_cnt steps 1, 1, 1, 1, then 0.
- Stall: stream 8'h01, 8'h02, 8'h03, 8'h04 with en = 0 for 2 cycles after the second word.
  - Required: the outputs appear in order 01..04, each with out_valid = 1 and no duplicates.
  - Required: the first word is delayed by 2 cycles, and fill_cnt peaks at 4.
- LOAD_ALL then SHIFT: LOAD_ALL with d = 8'h3C and in_valid = 1, then 4 SHIFT cycles with in_valid = 0.
  - Required: fill_cnt reads 4, 3, 2, 1, 0.
  - Required: q = 8'h3C with out_valid = 1 for 4 cycles.
- Flush mid-stream: after 2 valid SHIFTs (fill_cnt = 2), apply FLUSH.
  - Required on the next cycle: fill_cnt = 0, out_valid = 0, q = 8'h00.
  - Required: no flushed word ever appears with out_valid = 1.
- Reset versus mode: assert reset = 1 together with mode = LOAD_ALL and d = 8'h77.
  - Required: the reset values hold and 8'h77 never appears on q.

Source files
------------

// File: rtl/d_reg_pipe.sv
// rtl/d_reg_pipe.sv - WIDTH-bit, DEPTH-stage D register delay line with per-stage valid,
// enable/stall, mode-selected shift/hold/load/flush and an occupancy count.
module d_reg_pipe #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_n,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] fill_cnt
);

  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] MODE_HOLD     = 2'b00;
  localparam logic [1:0] MODE_SHIFT    = 2'b01;
  localparam logic [1:0] MODE_LOAD_ALL = 2'b10;
  localparam logic [1:0] MODE_FLUSH    = 2'b11;

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [CW-1:0]    cnt;

  // en = 0 takes precedence over mode; HOLD is the same as a disabled cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    vld_d = vld_q;
    if (en) begin
      case (mode)
        MODE_SHIFT: begin
          stage_d[0] = d;
          vld_d[0]   = in_valid;
          for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
            vld_d[i]   = vld_q[i-1];
          end
        end
        MODE_LOAD_ALL: begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = d;
          end
          vld_d = {DEPTH{in_valid}};
        end
        MODE_FLUSH: begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = RESET_VAL;
          end
          vld_d = '0;
        end
        MODE_HOLD: begin
          vld_d = vld_q;
        end
        default: begin
          vld_d = vld_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
      vld_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
      vld_q <= vld_d;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt = cnt + CW'(vld_q[i]);
    end
  end

  assign q         = stage_q[DEPTH-1];
  assign q_n       = ~stage_q[DEPTH-1];
  assign out_valid = vld_q[DEPTH-1];
  assign fill_cnt  = cnt;

endmodule
